// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) data-memory arbiter with weighted round robin and a DMA lock.
// Grants are combinational; read data returns one cycle after the grant. A requester that loses arbitration simply holds its request.
module dmem_arbiter #(
    parameter int CPU_WEIGHT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic [3:0]  c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_lock,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic [31:0] m_daddr,
    output logic [31:0] m_dwdata,
    output logic [3:0]  m_we,
    input  logic [31:0] m_drdata
);

    typedef enum logic {ARB, LOCK} state_t;

    localparam logic [3:0] WEIGHT = 4'(CPU_WEIGHT);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       c_rd_pend, d_rd_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB;
            cnt       <= 4'd0;
            c_rd_pend <= 1'b0;
            d_rd_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            c_rd_pend <= c_gnt && (c_we == 4'b0000);
            d_rd_pend <= d_gnt && (d_we == 4'b0000);
        end
    end

    always_comb begin
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;

        // Grants are gated by reset so the outputs go quiet the moment reset rises.
        if (!reset) begin
            if (state == LOCK && d_lock) begin
                d_gnt = d_req;
            end else if (c_req && d_req) begin
                if (cnt < WEIGHT) c_gnt = 1'b1;
                else              d_gnt = 1'b1;
            end else begin
                c_gnt = c_req;
                d_gnt = d_req;
            end

            if (d_gnt || !d_req) cnt_nxt = 4'd0;
            else if (c_gnt)      cnt_nxt = cnt + 4'd1;

            if (d_gnt && d_lock)                   state_nxt = LOCK;
            else if (state == LOCK && !d_lock)     state_nxt = ARB;
        end
    end

    assign m_en     = c_gnt | d_gnt;
    assign m_we     = c_gnt ? c_we    : (d_gnt ? d_we    : 4'b0000);
    assign m_daddr  = c_gnt ? c_addr  : (d_gnt ? d_addr  : 32'd0);
    assign m_dwdata = c_gnt ? c_wdata : (d_gnt ? d_wdata : 32'd0);

    assign c_rvalid = c_rd_pend;
    assign d_rvalid = d_rd_pend;
    assign c_rdata  = c_rd_pend ? m_drdata : 32'd0;
    assign d_rdata  = d_rd_pend ? m_drdata : 32'd0;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: CPU_WEIGHT, default 3, max consecutive CPU grants while DMA waits (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 c_req  input  1  CPU requests a data-memory access this cycle.
REQ-005 c_we  input  4  CPU byte write enables; 4'b0000 = read.
REQ-006 c_addr / c_wdata  input  32 / 32  CPU address / write data.
REQ-007 c_gnt  output  1  CPU access issued to memory this cycle.
REQ-008 c_rvalid / c_rdata  output  1 / 32  CPU read data valid / read data.
REQ-009 d_req, d_we[4], d_addr[32], d_wdata[32]  input  DMA port, same meaning as CPU port.
REQ-010 d_lock  input  1  DMA requests exclusive ownership while high.
REQ-011 d_gnt, d_rvalid, d_rdata[32]  output  DMA port, same meaning as CPU port.
REQ-012 m_en  output  1  memory access strobe.
REQ-013 m_daddr / m_dwdata / m_we  output  32 / 32 / 4  memory address, write data, byte enables.
REQ-014 m_drdata  input  32  memory read data, valid one cycle after a read strobe.

Function
REQ-015 At most one of c_gnt, d_gnt SHALL be high in any cycle; grant is combinational from current requests and registered state.
REQ-016 Granted port's addr/wdata/we SHALL drive m_daddr/m_dwdata/m_we with m_en=1 in the grant cycle; no grant -> m_en=0, m_we=0, m_daddr=0, m_dwdata=0.
REQ-017 FSM states: ARB, LOCK; reset state ARB.
REQ-018 ARB, only c_req -> grant CPU; only d_req -> grant DMA; neither -> no grant.
REQ-019 ARB, both requesting: cnt < CPU_WEIGHT -> grant CPU, cnt+1; cnt == CPU_WEIGHT -> grant DMA.
REQ-020 cnt (4 bits) SHALL clear on any DMA grant and on any cycle with d_req=0; it SHALL never exceed CPU_WEIGHT.
REQ-021 DMA grant with d_lock=1 -> next state LOCK.
REQ-022 LOCK: c_gnt held 0 regardless of c_req; d_req grants DMA; d_lock=0 in a cycle -> that cycle arbitrates as ARB and next state ARB.
REQ-023 Granted read (we==0) SHALL assert that port's rvalid exactly one cycle later with rdata = m_drdata; writes produce no rvalid.
REQ-024 rdata of a port SHALL be 0 whenever its rvalid is 0.
REQ-025 Back-to-back reads on alternating ports SHALL each return rvalid on the correct port, one per cycle, no bubble.
REQ-026 Requester holds req/addr/we/wdata stable until gnt; arbiter imposes no other handshake.

Reset
REQ-027 reset high SHALL immediately force state ARB, cnt=0, all gnt/rvalid/m_en/m_we low, all data outputs 0.
REQ-028 Read granted in the cycle before reset asserts SHALL produce no rvalid.
REQ-029 First cycle after reset release arbitrates normally from ARB with cnt=0.

Verification
REQ-030 CPU read only, c_addr=0x100, m_drdata=0xDEADBEEF next cycle -> c_gnt=1, m_daddr=0x100, m_en=1; next cycle c_rvalid=1, c_rdata=0xDEADBEEF, d_rvalid=0.
REQ-031 Both request reads continuously, CPU_WEIGHT=3 -> grant sequence C,C,C,D,C,C,C,D; never simultaneous grants.
REQ-032 DMA write d_we=4'b0011, d_addr=0x40, d_wdata=0x1234 with d_lock=1, then c_req=1 for 3 cycles while d_lock=1 -> c_gnt=0 throughout; after d_lock=0 cycle, CPU granted next cycle.
REQ-033 CPU read granted, reset asserted asynchronously mid-next-cycle -> c_rvalid drops to 0 immediately, outputs 0, state ARB.
REQ-034 Alternating C read 0x10, D read 0x20, C read 0x30 on consecutive cycles -> rvalid on C, D, C in the three following cycles with matching m_drdata.
REQ-035 c_req only for 20 cycles with d_req=0 -> CPU granted every cycle, cnt stays 0; d_req rises -> DMA granted within CPU_WEIGHT+1 cycles.
